// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX stage: bubble encoding, forwarding select
// codes and the packed ID/EX register layout.
package pipe_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 5;

  localparam logic [OPW-1:0] NOP_OP = 5'b11111;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_EXMEM,
    FWD_MEMWB
  } fwd_sel_e;

  typedef struct packed {
    logic            valid;
    logic [OPW-1:0]  op_code;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
  } id_ex_t;

  // A bubble is an all-zero record carrying the NOP opcode.
  function automatic id_ex_t bubble_f();
    id_ex_t b;
    b         = '0;
    b.op_code = NOP_OP;
    return b;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand select for one ALU source: EX/MEM result, MEM/WB write-back data or
// the register-file value captured in ID/EX. x0 is never forwarded.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [4:0]   rs_addr_i,
  input  logic [W-1:0] rf_data_i,
  input  logic [4:0]   exmem_rd_i,
  input  logic         exmem_we_i,
  input  logic [W-1:0] exmem_data_i,
  input  logic [4:0]   memwb_rd_i,
  input  logic         memwb_we_i,
  input  logic [W-1:0] memwb_data_i,
  output logic [W-1:0] data_o
);

  fwd_sel_e sel;

  // Youngest producer wins: EX/MEM before MEM/WB before the register file.
  always_comb begin
    sel = FWD_RF;
    if (exmem_we_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == rs_addr_i)) begin
      sel = FWD_EXMEM;
    end else if (memwb_we_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == rs_addr_i)) begin
      sel = FWD_MEMWB;
    end
  end

  // Operand data for the selected source.
  always_comb begin
    data_o = rf_data_i;
    case (sel)
      FWD_EXMEM: data_o = exmem_data_i;
      FWD_MEMWB: data_o = memwb_data_i;
      default:   data_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Build option ID_EX_FORWARDING_EN: when defined, operands are forwarded from
// EX/MEM and MEM/WB and only load-use hazards stall. When undefined, the
// forwarding selects are tied off (operands come from the registered
// register-file data) and any RAW hazard against ID/EX or EX/MEM stalls.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned REGF_WIDTH = 32,
  parameter int unsigned OP_code    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [OP_code-1:0]    id_op_code,
  input  logic [REGF_WIDTH-1:0] id_rs1_data,
  input  logic [REGF_WIDTH-1:0] id_rs2_data,
  input  logic [REGF_WIDTH-1:0] id_imm,
  input  logic [4:0]            id_rs1_addr,
  input  logic [4:0]            id_rs2_addr,
  input  logic [4:0]            id_rd_addr,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic [4:0]            exmem_rd_addr,
  input  logic                  exmem_reg_write,
  input  logic [REGF_WIDTH-1:0] exmem_alu_result,
  input  logic [4:0]            memwb_rd_addr,
  input  logic                  memwb_reg_write,
  input  logic [REGF_WIDTH-1:0] memwb_wdata,
  output logic                  load_use_stall,
  output logic                  ex_valid,
  output logic [OP_code-1:0]    ex_op_code,
  output logic [REGF_WIDTH-1:0] ex_source1,
  output logic [REGF_WIDTH-1:0] ex_source2,
  output logic [REGF_WIDTH-1:0] ex_store_data,
  output logic [4:0]            ex_rd_addr,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg
);

  id_ex_t id_ex_q;
  id_ex_t id_ex_d;

  logic                  hazard;
  logic                  exmem_fwd_we;
  logic                  memwb_fwd_we;
  logic [REGF_WIDTH-1:0] rs1_fwd;
  logic [REGF_WIDTH-1:0] rs2_fwd;

  logic rs1_hit_idex;
  logic rs2_hit_idex;
  assign rs1_hit_idex = (id_rs1_addr == id_ex_q.rd_addr);
  assign rs2_hit_idex = (id_rs2_addr == id_ex_q.rd_addr);

`ifdef ID_EX_FORWARDING_EN
  assign exmem_fwd_we = exmem_reg_write;
  assign memwb_fwd_we = memwb_reg_write;

  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  always_comb begin
    hazard = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd_addr != 5'd0) &&
             id_valid && (rs1_hit_idex || rs2_hit_idex);
  end
`else
  // Forwarding disabled: selects tied low so both muxes pass register-file data.
  assign exmem_fwd_we = 1'b0;
  assign memwb_fwd_we = 1'b0;

  // MEM/WB is never a hazard here: the register file writes before it reads.
  logic unused_memwb_we;
  assign unused_memwb_we = memwb_reg_write;

  // Any RAW dependency on ID/EX or EX/MEM must wait for write-back.
  always_comb begin
    hazard = id_valid &&
             ((id_ex_q.valid && id_ex_q.reg_write && (id_ex_q.rd_addr != 5'd0) &&
               (rs1_hit_idex || rs2_hit_idex)) ||
              (exmem_reg_write && (exmem_rd_addr != 5'd0) &&
               ((id_rs1_addr == exmem_rd_addr) || (id_rs2_addr == exmem_rd_addr))));
  end
`endif

  // A redirect discards the consumer, so no stall is requested during flush.
  assign load_use_stall = hazard && !flush;

  // Next ID/EX contents: flush > stall > hazard bubble > normal load.
  always_comb begin
    id_ex_d = id_ex_q;
    if (flush) begin
      id_ex_d = bubble_f();
    end else if (stall) begin
      id_ex_d = id_ex_q;
    end else if (hazard) begin
      id_ex_d = bubble_f();
    end else begin
      id_ex_d.valid      = id_valid;
      id_ex_d.op_code    = id_op_code;
      id_ex_d.rs1_data   = id_rs1_data;
      id_ex_d.rs2_data   = id_rs2_data;
      id_ex_d.imm        = id_imm;
      id_ex_d.rs1_addr   = id_rs1_addr;
      id_ex_d.rs2_addr   = id_rs2_addr;
      id_ex_d.rd_addr    = id_rd_addr;
      id_ex_d.alu_src    = id_alu_src;
      id_ex_d.reg_write  = id_reg_write;
      id_ex_d.mem_read   = id_mem_read;
      id_ex_d.mem_write  = id_mem_write;
      id_ex_d.mem_to_reg = id_mem_to_reg;
    end
  end

  // ID/EX register; reset loads a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_q <= bubble_f();
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  fwd_mux #(.W(REGF_WIDTH)) u_fwd_rs1 (
    .rs_addr_i    (id_ex_q.rs1_addr),
    .rf_data_i    (id_ex_q.rs1_data),
    .exmem_rd_i   (exmem_rd_addr),
    .exmem_we_i   (exmem_fwd_we),
    .exmem_data_i (exmem_alu_result),
    .memwb_rd_i   (memwb_rd_addr),
    .memwb_we_i   (memwb_fwd_we),
    .memwb_data_i (memwb_wdata),
    .data_o       (rs1_fwd)
  );

  fwd_mux #(.W(REGF_WIDTH)) u_fwd_rs2 (
    .rs_addr_i    (id_ex_q.rs2_addr),
    .rf_data_i    (id_ex_q.rs2_data),
    .exmem_rd_i   (exmem_rd_addr),
    .exmem_we_i   (exmem_fwd_we),
    .exmem_data_i (exmem_alu_result),
    .memwb_rd_i   (memwb_rd_addr),
    .memwb_we_i   (memwb_fwd_we),
    .memwb_data_i (memwb_wdata),
    .data_o       (rs2_fwd)
  );

  assign ex_valid      = id_ex_q.valid;
  assign ex_op_code    = id_ex_q.op_code;
  assign ex_source1    = rs1_fwd;
  assign ex_source2    = id_ex_q.alu_src ? id_ex_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign ex_rd_addr    = id_ex_q.rd_addr;
  assign ex_reg_write  = id_ex_q.reg_write;
  assign ex_mem_read   = id_ex_q.mem_read;
  assign ex_mem_write  = id_ex_q.mem_write;
  assign ex_mem_to_reg = id_ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations follow ID_EX_FORWARDING_EN.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_op_code;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic [4:0]  exmem_rd_addr;
  logic        exmem_reg_write;
  logic [31:0] exmem_alu_result;
  logic [4:0]  memwb_rd_addr;
  logic        memwb_reg_write;
  logic [31:0] memwb_wdata;
  logic        load_use_stall;
  logic        ex_valid;
  logic [4:0]  ex_op_code;
  logic [31:0] ex_source1, ex_source2, ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int tests;
  int fails;

  id_ex_stage #(.REGF_WIDTH(32), .OP_code(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .id_valid         (id_valid),
    .id_op_code       (id_op_code),
    .id_rs1_data      (id_rs1_data),
    .id_rs2_data      (id_rs2_data),
    .id_imm           (id_imm),
    .id_rs1_addr      (id_rs1_addr),
    .id_rs2_addr      (id_rs2_addr),
    .id_rd_addr       (id_rd_addr),
    .id_alu_src       (id_alu_src),
    .id_reg_write     (id_reg_write),
    .id_mem_read      (id_mem_read),
    .id_mem_write     (id_mem_write),
    .id_mem_to_reg    (id_mem_to_reg),
    .exmem_rd_addr    (exmem_rd_addr),
    .exmem_reg_write  (exmem_reg_write),
    .exmem_alu_result (exmem_alu_result),
    .memwb_rd_addr    (memwb_rd_addr),
    .memwb_reg_write  (memwb_reg_write),
    .memwb_wdata      (memwb_wdata),
    .load_use_stall   (load_use_stall),
    .ex_valid         (ex_valid),
    .ex_op_code       (ex_op_code),
    .ex_source1       (ex_source1),
    .ex_source2       (ex_source2),
    .ex_store_data    (ex_store_data),
    .ex_rd_addr       (ex_rd_addr),
    .ex_reg_write     (ex_reg_write),
    .ex_mem_read      (ex_mem_read),
    .ex_mem_write     (ex_mem_write),
    .ex_mem_to_reg    (ex_mem_to_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] op,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                        input logic asrc, input logic rw, input logic mr,
                        input logic mw, input logic m2r);
    id_valid      = v;
    id_op_code    = op;
    id_rs1_data   = d1;
    id_rs2_data   = d2;
    id_imm        = im;
    id_rs1_addr   = a1;
    id_rs2_addr   = a2;
    id_rd_addr    = rd;
    id_alu_src    = asrc;
    id_reg_write  = rw;
    id_mem_read   = mr;
    id_mem_write  = mw;
    id_mem_to_reg = m2r;
  endtask

  task automatic clear_fwd();
    exmem_rd_addr    = 5'd0;
    exmem_reg_write  = 1'b0;
    exmem_alu_result = 32'd0;
    memwb_rd_addr    = 5'd0;
    memwb_reg_write  = 1'b0;
    memwb_wdata      = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    clear_fwd();
    set_id(0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    set_id(1, 5'h03, 32'h1234, 32'h5678, 32'h9ABC, 5'd1, 5'd2, 5'd3, 0, 1, 1, 1, 1);
    tick();
    tests++;
    if (ex_valid !== 1'b1 || ex_op_code !== 5'h03) begin
      fails++;
      $display("FAIL reset_preload: valid=%b op=%h required valid=1 op=03", ex_valid, ex_op_code);
    end
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if ({ex_valid, ex_op_code, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
         ex_mem_to_reg, load_use_stall} !== {1'b0, 5'h1F, 5'd0, 4'b0000, 1'b0}) begin
      fails++;
      $display("FAIL reset_ctrl: valid=%b op=%h rd=%0d ctl=%b%b%b%b lus=%b required op=1f rest 0",
               ex_valid, ex_op_code, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, load_use_stall);
    end
    tests++;
    if ({ex_source1, ex_source2, ex_store_data} !== 96'd0) begin
      fails++;
      $display("FAIL reset_data: s1=%h s2=%h st=%h required 0", ex_source1, ex_source2, ex_store_data);
    end
    #1;
    set_id(0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pass_through();
    set_id(1, 5'h00, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0);
    tick();
    tests++;
    if ({ex_valid, ex_op_code, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}
        !== {1'b1, 5'h00, 5'd3, 4'b1000}) begin
      fails++;
      $display("FAIL pass_ctrl: valid=%b op=%h rd=%0d required 1 00 3", ex_valid, ex_op_code, ex_rd_addr);
    end
    tests++;
    if ({ex_source1, ex_source2, ex_store_data} !== {32'h11, 32'h22, 32'h22}) begin
      fails++;
      $display("FAIL pass_data: s1=%h s2=%h st=%h required 11 22 22", ex_source1, ex_source2, ex_store_data);
    end
    set_id(1, 5'h04, 32'hA0, 32'hB0, 32'h44, 5'd4, 5'd6, 5'd8, 1, 1, 0, 1, 1);
    tick();
    tests++;
    if ({ex_source2, ex_store_data} !== {32'h44, 32'hB0}) begin
      fails++;
      $display("FAIL pass_imm: s2=%h st=%h required 44 b0", ex_source2, ex_store_data);
    end
    tests++;
    if ({ex_op_code, ex_rd_addr, ex_mem_write, ex_mem_to_reg} !== {5'h04, 5'd8, 2'b11}) begin
      fails++;
      $display("FAIL pass_ctrl2: op=%h rd=%0d mw=%b m2r=%b required 04 8 1 1",
               ex_op_code, ex_rd_addr, ex_mem_write, ex_mem_to_reg);
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] exp;
    clear_fwd();
    set_id(1, 5'h00, 32'h55, 32'h66, 32'h0, 5'd5, 5'd6, 5'd9, 0, 1, 0, 0, 0);
    tick();
    id_valid = 1'b0;
    exmem_rd_addr = 5'd5; exmem_reg_write = 1'b1; exmem_alu_result = 32'h10;
    memwb_rd_addr = 5'd5; memwb_reg_write = 1'b1; memwb_wdata = 32'h20;
    #1;
`ifdef ID_EX_FORWARDING_EN
    exp = 32'h10;
`else
    exp = 32'h55;
`endif
    tests++;
    if (ex_source1 !== exp) begin
      fails++;
      $display("FAIL fwd_exmem_priority: s1=%h required %h", ex_source1, exp);
    end
    exmem_reg_write = 1'b0;
    #1;
`ifdef ID_EX_FORWARDING_EN
    exp = 32'h20;
`else
    exp = 32'h55;
`endif
    tests++;
    if (ex_source1 !== exp) begin
      fails++;
      $display("FAIL fwd_memwb: s1=%h required %h", ex_source1, exp);
    end
    memwb_rd_addr = 5'd6;
    #1;
`ifdef ID_EX_FORWARDING_EN
    exp = 32'h20;
`else
    exp = 32'h66;
`endif
    tests++;
    if (ex_store_data !== exp || ex_source2 !== exp || ex_source1 !== 32'h55) begin
      fails++;
      $display("FAIL fwd_rs2: st=%h s2=%h s1=%h required %h %h 55", ex_store_data, ex_source2,
               ex_source1, exp, exp);
    end
    clear_fwd();
    set_id(1, 5'h00, 32'h0, 32'h77, 32'h0, 5'd0, 5'd6, 5'd10, 0, 1, 0, 0, 0);
    tick();
    id_valid = 1'b0;
    exmem_rd_addr = 5'd0; exmem_reg_write = 1'b1; exmem_alu_result = 32'hDEADBEEF;
    memwb_rd_addr = 5'd0; memwb_reg_write = 1'b1; memwb_wdata = 32'hCAFE;
    #1;
    tests++;
    if (ex_source1 !== 32'h0) begin
      fails++;
      $display("FAIL x0_guard: s1=%h required 0", ex_source1);
    end
    clear_fwd();
  endtask

  task automatic test_raw_hazard();
    logic exp;
    set_id(1, 5'h00, 32'h1, 32'h2, 32'h0, 5'd12, 5'd6, 5'd13, 0, 1, 0, 0, 0);
    exmem_rd_addr = 5'd12; exmem_reg_write = 1'b1;
    #1;
`ifdef ID_EX_FORWARDING_EN
    exp = 1'b0;
`else
    exp = 1'b1;
`endif
    tests++;
    if (load_use_stall !== exp) begin
      fails++;
      $display("FAIL raw_exmem_stall: lus=%b required %b", load_use_stall, exp);
    end
    exmem_reg_write = 1'b0;
    memwb_rd_addr = 5'd12; memwb_reg_write = 1'b1;
    #1;
    tests++;
    if (load_use_stall !== 1'b0) begin
      fails++;
      $display("FAIL raw_memwb_nostall: lus=%b required 0", load_use_stall);
    end
    clear_fwd();
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    logic exp;
    clear_fwd();
    set_id(1, 5'h08, 32'h100, 32'h0, 32'h4, 5'd2, 5'd0, 5'd7, 1, 1, 1, 0, 1);
    tick();
    set_id(1, 5'h00, 32'h1, 32'h2, 32'h0, 5'd1, 5'd7, 5'd11, 0, 1, 0, 0, 0);
    #1;
    tests++;
    if (load_use_stall !== 1'b1) begin
      fails++;
      $display("FAIL load_use_detect: lus=%b required 1", load_use_stall);
    end
    tick();
    tests++;
    if ({ex_valid, ex_op_code, ex_rd_addr, ex_mem_read} !== {1'b0, 5'h1F, 5'd0, 1'b0}) begin
      fails++;
      $display("FAIL load_use_bubble: valid=%b op=%h rd=%0d mr=%b required 0 1f 0 0",
               ex_valid, ex_op_code, ex_rd_addr, ex_mem_read);
    end
    exmem_rd_addr = 5'd7; exmem_reg_write = 1'b1; exmem_alu_result = 32'h104;
    #1;
`ifdef ID_EX_FORWARDING_EN
    exp = 1'b0;
`else
    exp = 1'b1;
`endif
    tests++;
    if (load_use_stall !== exp) begin
      fails++;
      $display("FAIL load_use_release: lus=%b required %b", load_use_stall, exp);
    end
    id_valid = 1'b0;
    clear_fwd();
    tick();
  endtask

  task automatic test_flush_over_stall();
    set_id(1, 5'h08, 32'h200, 32'h0, 32'h8, 5'd3, 5'd0, 5'd7, 1, 1, 1, 0, 1);
    tick();
    set_id(1, 5'h00, 32'h9, 32'h8, 32'h0, 5'd7, 5'd4, 5'd12, 0, 1, 0, 0, 0);
    #1;
    tests++;
    if (load_use_stall !== 1'b1) begin
      fails++;
      $display("FAIL flush_pre_hazard: lus=%b required 1", load_use_stall);
    end
    flush = 1'b1;
    stall = 1'b1;
    #1;
    tests++;
    if (load_use_stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_masks_stall: lus=%b required 0", load_use_stall);
    end
    tick();
    tests++;
    if ({ex_valid, ex_op_code, ex_rd_addr, ex_reg_write, ex_mem_read, ex_source1}
        !== {1'b0, 5'h1F, 5'd0, 1'b0, 1'b0, 32'd0}) begin
      fails++;
      $display("FAIL flush_bubble: valid=%b op=%h rd=%0d rw=%b mr=%b s1=%h required 0 1f 0 0 0 0",
               ex_valid, ex_op_code, ex_rd_addr, ex_reg_write, ex_mem_read, ex_source1);
    end
    flush = 1'b0;
    stall = 1'b0;
    id_valid = 1'b0;
  endtask

  task automatic test_stall_hold();
    set_id(1, 5'h02, 32'hAAAA, 32'hBBBB, 32'hCCCC, 5'd13, 5'd14, 5'd15, 0, 1, 0, 0, 0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'(i + 5), 32'(i + 1), 32'(i + 100), 32'(i + 200),
             5'(16 + i), 5'(17 + i), 5'(20 + i), 1, 0, 1, 1, 1);
      tick();
      tests++;
      if ({ex_valid, ex_op_code, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_source1, ex_source2, ex_store_data}
          !== {1'b1, 5'h02, 5'd15, 1'b1, 1'b0, 1'b0, 32'hAAAA, 32'hBBBB, 32'hBBBB}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: op=%h rd=%0d s1=%h s2=%h st=%h required 02 15 aaaa bbbb bbbb",
                 i, ex_op_code, ex_rd_addr, ex_source1, ex_source2, ex_store_data);
      end
    end
    stall = 1'b0;
    tick();
    tests++;
    if ({ex_op_code, ex_rd_addr, ex_source2} !== {5'h07, 5'd22, 32'd202}) begin
      fails++;
      $display("FAIL stall_release: op=%h rd=%0d s2=%h required 07 22 ca",
               ex_op_code, ex_rd_addr, ex_source2);
    end
  endtask

  task automatic test_reset_mid_stall();
    stall = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    tests++;
    if ({ex_valid, ex_op_code, ex_rd_addr} !== {1'b0, 5'h1F, 5'd0}) begin
      fails++;
      $display("FAIL reset_mid_stall: valid=%b op=%h rd=%0d required 0 1f 0",
               ex_valid, ex_op_code, ex_rd_addr);
    end
    #1;
    rst = 1'b0;
    tick();
    tests++;
    if ({ex_valid, ex_op_code, ex_source1} !== {1'b0, 5'h1F, 32'd0}) begin
      fails++;
      $display("FAIL reset_stall_not_retained: valid=%b op=%h s1=%h required 0 1f 0",
               ex_valid, ex_op_code, ex_source1);
    end
    stall = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_pass_through();
    test_forwarding();
    test_raw_hazard();
    test_load_use();
    test_flush_over_stall();
    test_stall_hold();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the pipelined RISC-V core. It sits directly upstream of the ALU: it registers decoded instruction fields and presents forwarded operands to the ALU's `op_code`, `source1` and `source2` inputs. It also handles stall, flush and load-use bubbles, and produces the load-use stall request for the front end.

## Interface
Parameters:
- `REGF_WIDTH`, 32, datapath width
- `OP_code`, 5, ALU opcode width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  hold all registers (downstream wait)
- `flush`  in  1  load a bubble (branch redirect)
- `id_valid`  in  1  decode-stage instruction valid
- `id_op_code`  in  OP_code  ALU opcode
- `id_rs1_data`, `id_rs2_data`, `id_imm`  in  REGF_WIDTH  register-file read data and immediate
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr`  in  5  register indices
- `id_alu_src`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`  in  1  control bits
- `exmem_rd_addr`  in  5  EX/MEM destination register
- `exmem_reg_write`  in  1  EX/MEM writes a register
- `exmem_alu_result`  in  REGF_WIDTH  EX/MEM result
- `memwb_rd_addr`  in  5  MEM/WB destination register
- `memwb_reg_write`  in  1  MEM/WB writes a register
- `memwb_wdata`  in  REGF_WIDTH  MEM/WB write-back data
- `load_use_stall`  out  1  combinational; front end must hold PC and IF/ID
- `ex_valid`  out  1  EX instruction valid
- `ex_op_code`  out  OP_code  to ALU `op_code`
- `ex_source1`, `ex_source2`  out  REGF_WIDTH  to ALU operands
- `ex_store_data`  out  REGF_WIDTH  forwarded rs2, used as store data
- `ex_rd_addr`  out  5  destination register
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`  out  1  control bits passed through

## Operation
- Register update priority: `rst` > `flush` > `stall` > load-use bubble > normal load.
- Bubble contents:
  - `ex_valid`=0 and `ex_op_code`=5'b11111 (NOP)
  - all control bits 0
  - data and address fields 0
- `stall`=1 with `flush`=0: every register holds. A pending load-use does not insert a bubble while stalled.
- Load-use condition:
  - true when all of these hold: ID/EX `valid`, `mem_read`, rd≠0, `id_valid`, and (`id_rs1_addr`==rd or `id_rs2_addr`==rd)
  - effect: `load_use_stall`=1 and the register loads a bubble
  - `load_use_stall` is masked to 0 while `flush`=1
- Forwarding, evaluated per operand on the registered rs1/rs2 address:
  - EX/MEM hit (`exmem_reg_write`, rd≠0, address match) takes priority
  - otherwise MEM/WB hit (same conditions) is used
  - otherwise the registered register-file data is used
  - x0 is never forwarded
- `ex_source1` = forwarded rs1.
- `ex_source2` = `ex_alu_src` ? registered immediate : forwarded rs2.
- `ex_store_data` = forwarded rs2 in every case.

## Timing
- Reset:
  - all outputs 0, except `ex_op_code`=5'b11111
  - `load_use_stall`=0
- Latency: decode inputs appear on `ex_*` one cycle later.
- Forwarding muxes are combinational on the registered fields. Same-cycle changes on the EX/MEM and MEM/WB ports propagate to `ex_source*` without a clock.
- Load-use sequence:
  - cycle N: `load_use_stall`=1
  - cycle N+1: ID/EX holds a bubble; the held consumer is re-presented with the load now in EX/MEM; `load_use_stall`=0
  - the loaded value is forwarded from MEM/WB one cycle after that
- Reset asserted mid-stall clears state immediately (asynchronous); stall state is not retained.

## Configuration
- `ID_EX_FORWARDING_EN` defined: behaviour exactly as above.
- Not defined:
  - forwarding muxes are removed; `ex_source1` and `ex_store_data` come straight from the registered register-file data
  - `load_use_stall` covers any RAW hazard: an `id_rs*` address matching either the ID/EX rd (with `reg_write`) or `exmem_rd_addr` (with `exmem_reg_write`), rd≠0
  - MEM/WB needs no stall: the register file writes before it reads
  - forwarding ports remain present but unused

## Structure
- Shared package `pipe_pkg`:
  - `NOP_OP` = 5'b11111
  - `fwd_sel_e` enum {FWD_RF, FWD_EXMEM, FWD_MEMWB}
  - packed struct `id_ex_t` holding every registered field
- Sub-module `fwd_mux`: operand-select logic, instantiated once per operand.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `ex_op_code`=5'b11111, `ex_valid`=0, every other output 0.
- EX/MEM priority: ADD in EX with rs1=x5; EX/MEM rd=x5 with result 0x10; MEM/WB rd=x5 with 0x20 → `ex_source1`=0x10.
- Load-use: ID/EX holds LW to x7; decode presents ADD with rs2=x7 → `load_use_stall`=1 that cycle; next cycle `ex_valid`=0 and `ex_op_code`=5'b11111.
- Flush over stall: `flush`=1 and `stall`=1 together → bubble loaded, `load_use_stall`=0.
- Stall hold: `stall`=1 for 3 cycles while the decode inputs change → all registered outputs unchanged.
- x0 guard: EX/MEM rd=x0 with `exmem_reg_write`=1 and consumer rs1=x0 → `ex_source1`=registered register-file data (0).
